// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - shift/LHI issue stage with operand forwarding and a skid buffer
//
// Captures one decoded shift/LHI op per cycle, resolves operand forwarding at
// acceptance, and presents the op to the shift unit from flops. A single skid
// register absorbs the op accepted in the cycle backpressure first appears.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           upstream handshake
//   in_a, in_b, in_rs1, in_rs2    operands (register-file values) and source indices
//   in_b_imm                      in_b is an immediate and is never forwarded
//   in_ctr, in_rd, in_wen         op select, destination index, write enable
//   fx_wen, fx_rd, fx_data        EX/MEM forwarding source (higher priority)
//   fw_wen, fw_rd, fw_data        MEM/WB forwarding source
//   flush                         synchronous kill of everything held and offered
//   out_valid / out_ready         downstream handshake
//   out_a, out_b, out_ctr,
//   out_rd, out_wen               registered op fields
module shift_issue_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_b_imm,
  input  logic [1:0]    in_ctr,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wen,
  input  logic          fx_wen,
  input  logic [RW-1:0] fx_rd,
  input  logic [W-1:0]  fx_data,
  input  logic          fw_wen,
  input  logic [RW-1:0] fw_rd,
  input  logic [W-1:0]  fw_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [1:0]    out_ctr,
  output logic [RW-1:0] out_rd,
  output logic          out_wen
);

  logic          main_valid, skid_valid, ready_q;
  logic          main_valid_n, skid_valid_n;
  logic [W-1:0]  skid_a, skid_b;
  logic [1:0]    skid_ctr;
  logic [RW-1:0] skid_rd;
  logic          skid_wen;
  logic          accept, deliver, main_free;
  logic [W-1:0]  fwd_a, fwd_b;

  assign in_ready  = ready_q;
  assign out_valid = main_valid;

  assign accept    = in_valid && ready_q && !flush;
  assign deliver   = main_valid && out_ready;
  // Main can take a new entry this edge if it is empty or its op is leaving.
  assign main_free = !main_valid || deliver;

  // Forwarding: EX/MEM wins over MEM/WB; index 0 is the hardwired zero register.
  always_comb begin
    fwd_a = in_a;
    if (in_rs1 != '0 && fx_wen && fx_rd == in_rs1)
      fwd_a = fx_data;
    else if (in_rs1 != '0 && fw_wen && fw_rd == in_rs1)
      fwd_a = fw_data;

    fwd_b = in_b;
    if (!in_b_imm) begin
      if (in_rs2 != '0 && fx_wen && fx_rd == in_rs2)
        fwd_b = fx_data;
      else if (in_rs2 != '0 && fw_wen && fw_rd == in_rs2)
        fwd_b = fw_data;
    end
  end

  // Skid only ever fills while main is stalled, so skid_valid implies main_valid
  // and an occupied skid always drains into main before new input is taken.
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (main_free) begin
      main_valid_n = skid_valid || accept;
      skid_valid_n = 1'b0;
    end else if (accept) begin
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      out_a      <= '0;
      out_b      <= '0;
      out_ctr    <= 2'b00;
      out_rd     <= '0;
      out_wen    <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_ctr   <= 2'b00;
      skid_rd    <= '0;
      skid_wen   <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      // Ready is registered from the next skid state so in_ready never
      // depends combinationally on out_ready.
      ready_q    <= !skid_valid_n;
      if (!flush) begin
        if (main_free) begin
          if (skid_valid) begin
            out_a   <= skid_a;
            out_b   <= skid_b;
            out_ctr <= skid_ctr;
            out_rd  <= skid_rd;
            out_wen <= skid_wen;
          end else if (accept) begin
            out_a   <= fwd_a;
            out_b   <= fwd_b;
            out_ctr <= in_ctr;
            out_rd  <= in_rd;
            out_wen <= in_wen;
          end
        end else if (accept) begin
          skid_a   <= fwd_a;
          skid_b   <= fwd_b;
          skid_ctr <= in_ctr;
          skid_rd  <= in_rd;
          skid_wen <= in_wen;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - testbench for shift_issue_stage
module tb_shift_issue_stage;
  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_b_imm = 1'b0, in_wen = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [1:0]    in_ctr = 2'b00;
  logic          fx_wen = 1'b0, fw_wen = 1'b0;
  logic [RW-1:0] fx_rd = '0, fw_rd = '0;
  logic [W-1:0]  fx_data = '0, fw_data = '0;
  logic          flush = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_wen;
  logic [W-1:0]  out_a, out_b;
  logic [1:0]    out_ctr;
  logic [RW-1:0] out_rd;

  always #5 clk = ~clk;

  shift_issue_stage #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_b_imm(in_b_imm), .in_ctr(in_ctr), .in_rd(in_rd), .in_wen(in_wen),
    .fx_wen(fx_wen), .fx_rd(fx_rd), .fx_data(fx_data),
    .fw_wen(fw_wen), .fw_rd(fw_rd), .fw_data(fw_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctr(out_ctr), .out_rd(out_rd), .out_wen(out_wen)
  );

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    ctr;
    logic [RW-1:0] rd;
    logic          wen;
  } op_t;

  // Reference model: the stage behaves as an in-order queue holding at most two ops.
  op_t         q[$];
  logic [W-1:0] del_log[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [RW-1:0] src, input logic [W-1:0] rf);
    if (src != 0 && fx_wen && fx_rd == src) return fx_data;
    if (src != 0 && fw_wen && fw_rd == src) return fw_data;
    return rf;
  endfunction

  task automatic compare_outputs();
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      check("out_a", {32'd0, out_a}, {32'd0, q[0].a});
      check("out_b", {32'd0, out_b}, {32'd0, q[0].b});
      check("out_ctr", {62'd0, out_ctr}, {62'd0, q[0].ctr});
      check("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
      check("out_wen", {63'd0, out_wen}, {63'd0, q[0].wen});
    end
  endtask

  // One clock: inputs are already driven (after a negedge); update the model at
  // the posedge and compare at the following negedge.
  task automatic tick();
    bit  acc, del;
    op_t op;
    acc = in_valid && (q.size() < 2) && !flush;
    del = (q.size() > 0) && out_ready;
    op.a   = pick(in_rs1, in_a);
    op.b   = in_b_imm ? in_b : pick(in_rs2, in_b);
    op.ctr = in_ctr;
    op.rd  = in_rd;
    op.wen = in_wen;
    if (del) del_log.push_back(out_a);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(op);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_b_imm = 0; in_wen = 0; in_a = '0; in_b = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_ctr = 2'b00;
    fx_wen = 0; fw_wen = 0; fx_rd = '0; fw_rd = '0; fx_data = '0; fw_data = '0;
    flush = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_out_a"}, {32'd0, out_a}, 64'd0);
    check({tag, "_out_b"}, {32'd0, out_b}, 64'd0);
    check({tag, "_out_ctr"}, {62'd0, out_ctr}, 64'd0);
    check({tag, "_out_rd"}, {59'd0, out_rd}, 64'd0);
    check({tag, "_out_wen"}, {63'd0, out_wen}, 64'd0);
  endtask

  initial begin
    int k;
    int guard;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic SRA op, one-cycle latency
    idle_inputs();
    out_ready = 1; in_valid = 1; in_a = 32'h8000_0000; in_b = 32'd4; in_ctr = 2'b10;
    in_rs1 = 5'd7; in_rs2 = 5'd8; in_rd = 5'd9; in_wen = 1;
    tick();
    check("basic_valid", {63'd0, out_valid}, 64'd1);
    check("basic_a", {32'd0, out_a}, 64'h8000_0000);
    check("basic_b", {32'd0, out_b}, 64'd4);
    check("basic_ctr", {62'd0, out_ctr}, 64'd2);

    // Forward priority
    in_rs1 = 5'd3; in_a = 32'h1111; fx_wen = 1; fx_rd = 5'd3; fx_data = 32'hAAAA_0000;
    fw_wen = 1; fw_rd = 5'd3; fw_data = 32'h5555;
    tick();
    check("fwd_fx", {32'd0, out_a}, 64'hAAAA_0000);
    fx_rd = 5'd0;
    tick();
    check("fwd_fw", {32'd0, out_a}, 64'h5555);
    in_rs1 = 5'd0; fx_rd = 5'd0; fw_rd = 5'd0;
    tick();
    check("fwd_r0", {32'd0, out_a}, 64'h1111);

    // Immediate never forwarded
    in_b_imm = 1; in_ctr = 2'b11; in_b = 32'h1234; in_rs2 = 5'd6; fx_rd = 5'd6; fx_data = 32'hDEAD;
    tick();
    check("imm_b", {32'd0, out_b}, 64'h1234);
    check("imm_ctr", {62'd0, out_ctr}, 64'd3);

    // Drain, then backpressure with ops 1..4
    idle_inputs();
    tick();
    del_log.delete();
    out_ready = 0;
    k = 1;
    guard = 0;
    while (del_log.size() < 4 && guard < 40) begin
      in_valid = (k <= 4);
      in_a = k;
      if (guard == 3) out_ready = 1;
      if (guard == 2) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      if (guard == 2) check("bp_hold_op1", {32'd0, out_a}, 64'd1);
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    check("bp_delivered", del_log.size(), 64'd4);
    for (int i = 0; i < del_log.size(); i++)
      check("bp_order", {32'd0, del_log[i]}, i + 1);

    // Flush with main and skid full
    idle_inputs();
    tick();
    out_ready = 0; in_valid = 1; in_a = 32'h77;
    tick();
    in_a = 32'h78;
    tick();
    check("pre_flush_full", {63'd0, in_ready}, 64'd0);
    flush = 1; in_a = 32'h79;
    tick();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    flush = 0; in_valid = 0;
    tick();
    check("flush_dropped", {63'd0, out_valid}, 64'd0);

    // Randomized stream with occasional flush and mid-stream reset
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(15) == 0);
      in_a = $urandom; in_b = $urandom;
      in_rs1 = $urandom_range(3); in_rs2 = $urandom_range(3);
      in_b_imm = $urandom_range(1);
      in_ctr = $urandom_range(3); in_rd = $urandom_range(31); in_wen = $urandom_range(1);
      fx_wen = $urandom_range(1); fx_rd = $urandom_range(3); fx_data = $urandom;
      fw_wen = $urandom_range(1); fw_rd = $urandom_range(3); fw_data = $urandom;
      if (c == 300) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        out_ready = 1; in_valid = 1; in_a = 32'hC0FFEE;
        tick();
        check("post_reset_latency", {63'd0, out_valid}, 64'd1);
        check("post_reset_a", {32'd0, out_a}, 64'hC0FFEE);
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
